sa_result_drain: RTL and testbench

//  Output stage directly downstream of the systolic-array core. Snapshots one

---
 rtl/sa_result_drain_if.sv | 15 +
 rtl/sa_result_drain.sv | 165 ++++++++++++++++
 tb/tb_sa_result_drain.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/sa_result_drain_if.sv
// Result stream from sa_result_drain towards writeback/DMA: one column word per beat,
// valid/ready handshake, with column index and last-beat marker.
interface sa_result_drain_if #(
    parameter int DW = 32,
    parameter int CW = 3
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [CW-1:0] m_col;

    modport master (output m_data, output m_valid, output m_last, output m_col, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, input m_col, output m_ready);
endinterface

// File: rtl/sa_result_drain.sv
// Snapshots one row of systolic-array results and serialises it column 0 first.
// Optional feature macro SA_DRAIN_REQUANT_EN: shift-and-saturate each word to QWIDTH bits.
module sa_result_drain #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32,
    parameter int QWIDTH   = 8,
    parameter int QSHIFT   = 8,
    parameter int CNTWIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [OUTWIDTH-1:0] r_in [0:ROWS-1],
    input  logic        [0:ROWS-1]     r_valid,
    output logic                       r_read,
    sa_result_drain_if.master          m,
    output logic                       busy,
    output logic        [CNTWIDTH-1:0] tile_count
);
    localparam int CW = $clog2(ROWS);
`ifdef SA_DRAIN_REQUANT_EN
    localparam int DW = QWIDTH;
`else
    localparam int DW = OUTWIDTH;
`endif
    localparam logic [CW-1:0]       LAST_IDX = CW'(ROWS - 1);
    localparam logic [CW-1:0]       COL_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CNTWIDTH-1:0] CNT_ONE  = {{(CNTWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'd0, CAPT = 2'd1, STREAM = 2'd2, GAP = 2'd3} state_t;

    state_t                       state_r, state_s;
    logic signed [OUTWIDTH-1:0]   buf_r [0:ROWS-1];
    logic        [DW-1:0]         data_r, data_s;
    logic        [CW-1:0]         col_r, col_s;
    logic                         valid_r, valid_s;
    logic                         last_r, last_s;
    logic                         read_r, read_s;
    logic                         busy_r, busy_s;
    logic        [CNTWIDTH-1:0]   cnt_r, cnt_s;
    logic                         cap_s;

`ifdef SA_DRAIN_REQUANT_EN
    localparam logic signed [OUTWIDTH-1:0] Q_MAX = {{(OUTWIDTH-QWIDTH+1){1'b0}}, {(QWIDTH-1){1'b1}}};
    localparam logic signed [OUTWIDTH-1:0] Q_MIN = {{(OUTWIDTH-QWIDTH+1){1'b1}}, {(QWIDTH-1){1'b0}}};

    // Arithmetic shift truncates toward -inf; the result is then clamped to signed QWIDTH.
    function automatic logic [DW-1:0] fmt(input logic signed [OUTWIDTH-1:0] x);
        logic signed [OUTWIDTH-1:0] s;
        s = x >>> QSHIFT;
        if (s > Q_MAX) begin
            return Q_MAX[DW-1:0];
        end else if (s < Q_MIN) begin
            return Q_MIN[DW-1:0];
        end else begin
            return s[DW-1:0];
        end
    endfunction
`else
    function automatic logic [DW-1:0] fmt(input logic signed [OUTWIDTH-1:0] x);
        return x;
    endfunction
`endif

    // Next state and next registered output values.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        col_s   = col_r;
        valid_s = 1'b0;
        last_s  = 1'b0;
        read_s  = 1'b0;
        cnt_s   = cnt_r;
        cap_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (&r_valid) begin
                    state_s = CAPT;
                    read_s  = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            CAPT: begin
                cap_s   = 1'b1;
                state_s = STREAM;
                valid_s = 1'b1;
                data_s  = fmt(r_in[0]);
                col_s   = {CW{1'b0}};
                last_s  = (LAST_IDX == {CW{1'b0}});
            end
            STREAM: begin
                // m_valid is always high here, so m_ready alone means a transfer.
                if (m.m_ready) begin
                    if (col_r == LAST_IDX) begin
                        state_s = GAP;
                        col_s   = {CW{1'b0}};
                        cnt_s   = cnt_r + CNT_ONE;
                    end else begin
                        valid_s = 1'b1;
                        col_s   = col_r + COL_ONE;
                        data_s  = fmt(buf_r[col_s]);
                        last_s  = (col_s == LAST_IDX);
                    end
                end else begin
                    valid_s = 1'b1;
                    last_s  = last_r;
                end
            end
            GAP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered stream, strobe and counter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= {DW{1'b0}};
            col_r   <= {CW{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            read_r  <= 1'b0;
            busy_r  <= 1'b0;
            cnt_r   <= {CNTWIDTH{1'b0}};
        end else begin
            data_r  <= data_s;
            col_r   <= col_s;
            valid_r <= valid_s;
            last_r  <= last_s;
            read_r  <= read_s;
            busy_r  <= busy_s;
            cnt_r   <= cnt_s;
        end
    end

    // Snapshot buffer; contents are only meaningful after a capture.
    always_ff @(posedge clk) begin
        if (cap_s) begin
            buf_r <= r_in;
        end else begin
            buf_r <= buf_r;
        end
    end

    assign m.m_data   = data_r;
    assign m.m_valid  = valid_r;
    assign m.m_last   = last_r;
    assign m.m_col    = col_r;
    assign r_read     = read_r;
    assign busy       = busy_r;
    assign tile_count = cnt_r;
endmodule

// File: tb/tb_sa_result_drain.sv
// Directed bench for sa_result_drain: reset, basic drain, backpressure, partial valid,
// overlap, word formatting vectors and mid-stream reset.
module tb_sa_result_drain;
`ifdef SA_DRAIN_REQUANT_EN
    localparam int DW = 8;
`else
    localparam int DW = 32;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] r_in [0:7];
    logic        [0:7]  r_valid;
    logic               r_read;
    logic               busy;
    logic        [15:0] tile_count;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int vcyc;

    logic [31:0] d_base [0:7], e_base [0:7];
    logic [31:0] d_neg  [0:7], e_neg  [0:7];
    logic [31:0] d_new  [0:7], e_new  [0:7];
    logic [31:0] d_q    [0:7], e_q    [0:7];

    sa_result_drain_if #(.DW(DW), .CW(3)) s_if ();

    sa_result_drain dut (
        .clk        (clk),
        .rst        (rst),
        .r_in       (r_in),
        .r_valid    (r_valid),
        .r_read     (r_read),
        .m          (s_if),
        .busy       (busy),
        .tile_count (tile_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (r_read === 1'b1) rd_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] d [0:7]);
        for (int c = 0; c < 8; c++) r_in[c] = d[c];
    endtask

    // Consume one snapshot; mode 0 = always ready, mode 1 = ready pattern 1,0,0 repeating.
    task automatic drain(input logic [31:0] e [0:7], input int mode, output int vc);
        int k;
        k  = 0;
        vc = 0;
        for (int j = 0; j < 200 && k < 8; j++) begin
            if (s_if.m_valid) begin
                vc++;
                check_val("data", 32'(s_if.m_data), e[k]);
                check_val("col", 32'(s_if.m_col), k);
                check_val("last", 32'(s_if.m_last), 32'(k == 7));
            end
            s_if.m_ready = (mode == 0) ? 1'b1 : ((j % 3) == 0);
            if (s_if.m_valid && s_if.m_ready) k++;
            tick();
        end
        check_val("beats", k, 8);
        s_if.m_ready = 1'b1;
    endtask

    initial begin
        for (int c = 0; c < 8; c++) begin
            d_base[c] = 32'h0000_0100 * (c + 1);
            d_neg[c]  = 32'hFFFF_F000 + 32'h0000_0100 * c;
            d_new[c]  = 32'h0000_1000 + 32'h0000_0100 * c;
`ifdef SA_DRAIN_REQUANT_EN
            e_base[c] = 32'(c + 1);
            e_neg[c]  = 32'h0000_00F0 + 32'(c);
            e_new[c]  = 32'h0000_0010 + 32'(c);
`else
            e_base[c] = d_base[c];
            e_neg[c]  = d_neg[c];
            e_new[c]  = d_new[c];
`endif
        end
        d_q = '{32'h0000_7F00, 32'h0001_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                32'h0000_0000, 32'h0000_0100, 32'hFFFF_FF00, 32'h7FFF_FFFF};
`ifdef SA_DRAIN_REQUANT_EN
        e_q = '{32'h7F, 32'h7F, 32'hFF, 32'h80, 32'h00, 32'h01, 32'hFF, 32'h7F};
`else
        e_q = d_q;
`endif

        // Reset with r_valid all ones: nothing may happen
        rst = 1'b1;
        r_valid = 8'hFF;
        s_if.m_ready = 1'b1;
        load(d_base);
        tick(); tick(); tick();
        check_val("rst_m_valid", 32'(s_if.m_valid), 32'd0);
        check_val("rst_m_data", 32'(s_if.m_data), 32'd0);
        check_val("rst_m_last", 32'(s_if.m_last), 32'd0);
        check_val("rst_m_col", 32'(s_if.m_col), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_tile", 32'(tile_count), 32'd0);
        check_val("rst_r_read", 32'(r_read), 32'd0);
        check_val("rst_rd_cnt", rd_cnt, 0);
        r_valid = 8'h00;
        rst = 1'b0;
        tick();

        // Basic snapshot with m_ready held high
        load(d_base);
        r_valid = 8'hFF;
        tick();
        check_val("capt_r_read", 32'(r_read), 32'd1);
        check_val("capt_m_valid", 32'(s_if.m_valid), 32'd0);
        check_val("capt_busy", 32'(busy), 32'd1);
        r_valid = 8'h00;
        tick();
        check_val("first_valid", 32'(s_if.m_valid), 32'd1);
        check_val("read_once", 32'(r_read), 32'd0);
        drain(e_base, 0, vcyc);
        check_val("b2b_cycles", vcyc, 8);
        check_val("gap_valid", 32'(s_if.m_valid), 32'd0);
        check_val("gap_busy", 32'(busy), 32'd1);
        check_val("tile1", 32'(tile_count), 32'd1);
        tick();
        check_val("idle_busy", 32'(busy), 32'd0);
        check_val("rd_cnt1", rd_cnt, 1);

        // Backpressure
        load(d_neg);
        r_valid = 8'hFF;
        tick();
        r_valid = 8'h00;
        tick();
        drain(e_neg, 1, vcyc);
        check_val("tile2", 32'(tile_count), 32'd2);
        tick();

        // Partial valid is ignored
        load(d_base);
        r_valid = 8'h7F;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("part_r_read", 32'(r_read), 32'd0);
            check_val("part_busy", 32'(busy), 32'd0);
        end
        r_valid = 8'hFF;
        tick();
        check_val("part_capt", 32'(r_read), 32'd1);
        r_valid = 8'h00;
        tick();
        drain(e_base, 0, vcyc);
        check_val("tile3", 32'(tile_count), 32'd3);
        tick();

        // Overlap: r_valid stays high, new data arrives while streaming
        load(d_base);
        r_valid = 8'hFF;
        tick();
        tick();
        load(d_new);
        drain(e_base, 0, vcyc);
        check_val("ovl_gap_read", 32'(r_read), 32'd0);
        check_val("ovl_gap_busy", 32'(busy), 32'd1);
        tick();
        check_val("ovl_idle_busy", 32'(busy), 32'd0);
        check_val("ovl_idle_read", 32'(r_read), 32'd0);
        tick();
        check_val("ovl_capt2", 32'(r_read), 32'd1);
        r_valid = 8'h00;
        tick();
        drain(e_new, 0, vcyc);
        check_val("tile5", 32'(tile_count), 32'd5);
        check_val("rd_cnt5", rd_cnt, 5);
        tick();

        // Word formatting vectors (saturation when requant is built in)
        load(d_q);
        r_valid = 8'hFF;
        tick();
        r_valid = 8'h00;
        tick();
        drain(e_q, 0, vcyc);
        check_val("tile6", 32'(tile_count), 32'd6);
        tick();

        // Mid-stream reset discards the snapshot
        load(d_base);
        r_valid = 8'hFF;
        tick();
        r_valid = 8'h00;
        tick();
        tick(); tick(); tick();
        check_val("mid_valid_pre", 32'(s_if.m_valid), 32'd1);
        check_val("mid_col_pre", 32'(s_if.m_col), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_val("mid_valid", 32'(s_if.m_valid), 32'd0);
            check_val("mid_busy", 32'(busy), 32'd0);
            tick();
        end
        check_val("mid_tile", 32'(tile_count), 32'd0);
        check_val("mid_rd_cnt", rd_cnt, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
